ifu: RTL and testbench
======================

Name: ifu

Overview:
Instruction fetch unit: the supplier side of the core's instruction input. It takes the PC value and fetches the instruction word over a valid/ready memory request / response interface. It then presents the 32-bit instruction to the decode stage with a valid/ready handshake. It sits between the pc register and idu, replacing the externally driven inst word. It also flags the ebreak instruction for the simulation harness.

Parameters:
XLEN, 64, address and memory data width
ILEN, 32, instruction width
RESET_INST, 32'h00000013, value driven on inst while no valid instruction is held (nop)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
pc_val  input  XLEN  fetch address from the pc register
fetch_en  input  1  core requests a fetch of pc_val; sampled only in IDLE or on HOLD exit
mem_req_valid  output  1  memory read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  request address, 8-byte aligned (addr[2:0]=0)
mem_rsp_valid  input  1  read data valid (no backpressure)
mem_rsp_data  input  XLEN  read data, doubleword
inst  output  ILEN  fetched instruction
inst_valid  output  1  inst is valid
inst_ready  input  1  consumer accepts inst
busy  output  1  state != IDLE
is_ebreak  output  1  inst_valid && inst == 32'h00100073
inst_err  output  1  misaligned-fetch error (present only with the optional feature; tied 0 otherwise)

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. On rst the state is IDLE and the outputs are:
  - mem_req_valid=0, mem_req_addr=0, inst=RESET_INST, inst_valid=0, busy=0, is_ebreak=0, inst_err=0.
- IDLE, with fetch_en=1:
  - latch addr_q=pc_val; go to REQ.
- REQ:
  - mem_req_valid=1 and mem_req_addr={addr_q[XLEN-1:3],3'b0}, held stable until accepted.
  - mem_req_valid && mem_req_ready -> WAIT.
- WAIT:
  - on mem_rsp_valid, register the word selected by addr_q[2] (1 selects the upper 32 bits, 0 the lower) into inst; go to HOLD.
- HOLD:
  - inst_valid=1; inst stays stable until the handshake.
  - inst_valid && inst_ready with fetch_en=1: latch pc_val and go to REQ (back-to-back).
  - inst_valid && inst_ready with fetch_en=0: go to IDLE.
- Minimum latency: fetch_en at cycle 0 gives mem_req_valid at cycle 1. If ready is asserted that cycle, the unit is in WAIT at cycle 2. A response at cycle N gives inst_valid at cycle N+1.
- The memory must not return mem_rsp_valid in the request-accept cycle. mem_rsp_valid outside WAIT is ignored; no state change.
- Exactly one outstanding request; fetch_en outside IDLE/HOLD-exit is ignored.
- inst keeps its last value after HOLD exits; inst_valid drops the cycle after the handshake.
- Reset mid-operation (any state): return to IDLE next edge. A response arriving later from the dropped request is ignored.
- busy is a combinational decode of state; is_ebreak is combinational from registered inst/inst_valid.
- addr_q upper bits pass through unchanged. XLEN wrap is not checked.

Optional Feature:
IFU_MISALIGN_CHECK_EN
- Defined: in IDLE/HOLD-exit, fetch_en with pc_val[1:0]!=0 skips REQ and goes directly to HOLD.
  - inst=RESET_INST, inst_valid=1, inst_err=1; no memory request is issued.
  - inst_err clears on the HOLD handshake.
- Undefined: pc_val[1:0] is ignored (word selection uses addr_q[2] only); inst_err is tied 0.

Decomposition:
- Shared package ifu_pkg holds:
  - state enum (IDLE=0, REQ=1, WAIT=2, HOLD=3)
  - EBREAK_INST=32'h00100073
  - NOP_INST=32'h00000013
  - word-select helper constant WORD_SEL_BIT=2.
- No sub-module needed. Optional sub-module ifu_word_sel (64->32 mux) is permitted but kept inline by default.

Test Plan:
- Reset: rst=1 for 2 cycles with fetch_en=1 -> mem_req_valid=0, inst=32'h00000013, inst_valid=0, busy=0.
- Basic fetch, zero wait:
  - Stimulus: pc_val=64'h80000000, fetch_en pulse at cycle 0, mem_req_ready=1, rsp_data=64'hDEADBEEF_00100093 at cycle 3.
  - Response: mem_req_addr=64'h80000000 at cycle 1; inst=32'h00100093, inst_valid=1 at cycle 4.
- Upper-word select plus ebreak:
  - Stimulus: pc_val=64'h80000004, rsp_data=64'h00100073_00000000.
  - Response: inst=32'h00100073, is_ebreak=1 while in HOLD.
- Backpressure:
  - Stimulus: mem_req_ready=0 for 3 cycles; then inst_ready=0 for 4 cycles.
  - Response: mem_req_valid and mem_req_addr stable throughout; inst and inst_valid stable; no second request issued.
- Back-to-back: handshake in HOLD with fetch_en=1, pc_val=64'h80000008 -> mem_req_valid=1 with addr 64'h80000008 on the next cycle; IDLE never entered.
- Reset mid-WAIT:
  - Stimulus: rst in WAIT, then mem_rsp_valid arrives.
  - Response: state IDLE, inst_valid stays 0. With IFU_MISALIGN_CHECK_EN, pc_val=64'h80000002 -> inst_err=1, no mem_req_valid.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// well-known instruction encodings and the doubleword word-select bit.
package ifu_pkg;

  // Fetch FSM states; encodings are fixed so state dumps stay readable.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } ifu_state_e;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;
  localparam logic [31:0] NOP_INST    = 32'h00000013;

  // Address bit that picks the upper (1) or lower (0) word of a doubleword.
  localparam int unsigned WORD_SEL_BIT = 2;

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: takes a PC, issues one doubleword read over a
// valid/ready memory interface, extracts the addressed 32-bit instruction and
// hands it to decode with a valid/ready handshake. Flags ebreak for the
// simulation harness.
//
// Optional feature: define IFU_MISALIGN_CHECK_EN to trap fetches whose
// pc_val[1:0] is non-zero. Such fetches skip memory entirely and present a
// nop with inst_err set. Without the macro inst_err is tied low.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     ILEN       = 32,
  parameter logic [ILEN-1:0] RESET_INST = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_val,
  input  logic            fetch_en,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic [ILEN-1:0] inst,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            busy,
  output logic            is_ebreak,
  output logic            inst_err
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [ILEN-1:0] rsp_word;
  logic            launch;

`ifdef IFU_MISALIGN_CHECK_EN
  logic            inst_err_q, inst_err_d;
`endif

  // Byte offset within the word never affects the fetched data.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[1:0];

  // Pick the addressed 32-bit half of the returned doubleword.
  assign rsp_word = addr_q[WORD_SEL_BIT] ? mem_rsp_data[2*ILEN-1:ILEN]
                                         : mem_rsp_data[ILEN-1:0];

  // fetch_en only counts when idle, or on the cycle decode takes the held word.
  assign launch = fetch_en &&
                  ((state_q == StIdle) || ((state_q == StHold) && inst_ready));

  // Next-state logic: FSM transitions plus address/instruction capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
`ifdef IFU_MISALIGN_CHECK_EN
    inst_err_d = inst_err_q;
`endif

    unique case (state_q)
      StIdle: ;
      StReq: begin
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        // Responses in any other state are stray and ignored.
        if (mem_rsp_valid) begin
          inst_d  = rsp_word;
          state_d = StHold;
        end
      end
      StHold: begin
        if (inst_ready) begin
          state_d = StIdle;
`ifdef IFU_MISALIGN_CHECK_EN
          inst_err_d = 1'b0;
`endif
        end
      end
    endcase

    // A launch overrides the HOLD->IDLE exit for back-to-back fetches.
    if (launch) begin
      addr_d = pc_val;
`ifdef IFU_MISALIGN_CHECK_EN
      if (|pc_val[1:0]) begin
        state_d    = StHold;
        inst_d     = RESET_INST;
        inst_err_d = 1'b1;
      end else begin
        state_d = StReq;
      end
`else
      state_d = StReq;
`endif
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      inst_q  <= RESET_INST;
`ifdef IFU_MISALIGN_CHECK_EN
      inst_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
`ifdef IFU_MISALIGN_CHECK_EN
      inst_err_q <= inst_err_d;
`endif
    end
  end

  // Output decode; everything derives from registered state.
  always_comb begin
    mem_req_valid = (state_q == StReq);
    mem_req_addr  = mem_req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
    inst          = inst_q;
    inst_valid    = (state_q == StHold);
    busy          = (state_q != StIdle);
    is_ebreak     = inst_valid && (inst_q == EBREAK_INST);
`ifdef IFU_MISALIGN_CHECK_EN
    inst_err      = inst_err_q;
`else
    inst_err      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: table of single fetches with varying stall and
// latency, plus hand-written sequences for reset, back-to-back and mid-flight
// reset. Inputs change and outputs are sampled on the falling clock edge.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_val;
  logic        fetch_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        busy;
  logic        is_ebreak;
  logic        inst_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu dut (
    .clk           (clk),
    .rst           (rst),
    .pc_val        (pc_val),
    .fetch_en      (fetch_en),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .busy          (busy),
    .is_ebreak     (is_ebreak),
    .inst_err      (inst_err)
  );

  typedef struct {
    logic [63:0] pc;
    logic [63:0] data;
    int          req_stall;   // cycles mem_req_ready held low
    int          rsp_delay;   // WAIT cycles before the response
    int          hold_stall;  // HOLD cycles with inst_ready low
    logic [63:0] exp_addr;
    logic [31:0] exp_inst;
    logic        exp_ebreak;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_en      = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'h0;
    inst_ready    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    pc_val   = v.pc;
    fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0;
    chk("req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("req_addr", mem_req_addr, v.exp_addr);
    // Stray responses while the request is still pending must be ignored.
    for (int s = 0; s < v.req_stall; s++) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hBAD0BAD0_BAD0BAD0;
      cyc();
      chk("req_valid_stall", {63'd0, mem_req_valid}, 64'd1);
      chk("req_addr_stall", mem_req_addr, v.exp_addr);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    chk("req_drop", {63'd0, mem_req_valid}, 64'd0);
    chk("busy_wait", {63'd0, busy}, 64'd1);
    // fetch_en during WAIT must not start anything.
    for (int d = 0; d < v.rsp_delay; d++) begin
      fetch_en = 1'b1;
      cyc();
      chk("wait_no_valid", {63'd0, inst_valid}, 64'd0);
      chk("wait_no_req", {63'd0, mem_req_valid}, 64'd0);
    end
    fetch_en      = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = v.data;
    cyc();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'h0;
    chk("inst_valid", {63'd0, inst_valid}, 64'd1);
    chk("inst", {32'd0, inst}, {32'd0, v.exp_inst});
    chk("is_ebreak", {63'd0, is_ebreak}, {63'd0, v.exp_ebreak});
    for (int h = 0; h < v.hold_stall; h++) begin
      fetch_en = 1'b1;
      cyc();
      chk("hold_valid", {63'd0, inst_valid}, 64'd1);
      chk("hold_inst", {32'd0, inst}, {32'd0, v.exp_inst});
      chk("hold_no_req", {63'd0, mem_req_valid}, 64'd0);
    end
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("post_valid", {63'd0, inst_valid}, 64'd0);
    chk("post_busy", {63'd0, busy}, 64'd0);
    chk("post_inst_kept", {32'd0, inst}, {32'd0, v.exp_inst});
    chk("post_ebreak", {63'd0, is_ebreak}, 64'd0);
  endtask

  initial begin
    vecs.push_back('{64'h0000_0000_8000_0000, 64'hDEADBEEF_00100093, 0, 1, 0,
                     64'h0000_0000_8000_0000, 32'h00100093, 1'b0});
    vecs.push_back('{64'h0000_0000_8000_0004, 64'h00100073_00000000, 0, 0, 0,
                     64'h0000_0000_8000_0000, 32'h00100073, 1'b1});
    vecs.push_back('{64'h1234_5678_9ABC_DEF8, 64'h11223344_55667788, 3, 0, 4,
                     64'h1234_5678_9ABC_DEF8, 32'h55667788, 1'b0});
    vecs.push_back('{64'h0000_0000_0000_100C, 64'hCAFEF00D_0BADBEEF, 2, 3, 1,
                     64'h0000_0000_0000_1008, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF0, 64'h00100073_00100073, 1, 0, 2,
                     64'hFFFF_FFFF_FFFF_FFF0, 32'h00100073, 1'b1});
`ifndef IFU_MISALIGN_CHECK_EN
    // Low PC bits are ignored: 0x..06 selects the upper word of 0x..00.
    vecs.push_back('{64'h0000_0000_8000_0006, 64'hA5A5A5A5_5A5A5A5A, 0, 2, 0,
                     64'h0000_0000_8000_0000, 32'hA5A5A5A5, 1'b0});
`endif

    // Reset held with fetch_en asserted.
    idle_inputs();
    pc_val   = 64'h0000_0000_8000_0000;
    fetch_en = 1'b1;
    rst      = 1'b1;
    cyc();
    cyc();
    chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'h13);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ebreak", {63'd0, is_ebreak}, 64'd0);
    chk("rst_inst_err", {63'd0, inst_err}, 64'd0);
    rst      = 1'b0;
    fetch_en = 1'b0;
    cyc();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: handshake with fetch_en goes straight to REQ.
    pc_val   = 64'h0000_0000_8000_0000;
    fetch_en = 1'b1;
    cyc();
    fetch_en      = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h11111111_22222222;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("b2b_first_inst", {32'd0, inst}, 64'h22222222);
    pc_val     = 64'h0000_0000_8000_0008;
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    cyc();
    fetch_en   = 1'b0;
    inst_ready = 1'b0;
    chk("b2b_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("b2b_req_addr", mem_req_addr, 64'h0000_0000_8000_0008);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_valid_drop", {63'd0, inst_valid}, 64'd0);
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h0000AAAA_12345678;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("b2b_second_inst", {32'd0, inst}, 64'h12345678);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("b2b_done_busy", {63'd0, busy}, 64'd0);

    // Reset while waiting; the late response must be dropped.
    pc_val   = 64'h0000_0000_8000_0010;
    fetch_en = 1'b1;
    cyc();
    fetch_en      = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstw_busy", {63'd0, busy}, 64'd0);
    chk("rstw_req", {63'd0, mem_req_valid}, 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h00100073_00100073;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("rstw_valid", {63'd0, inst_valid}, 64'd0);
    chk("rstw_busy2", {63'd0, busy}, 64'd0);
    chk("rstw_inst", {32'd0, inst}, 64'h13);
    chk("rstw_ebreak", {63'd0, is_ebreak}, 64'd0);

`ifdef IFU_MISALIGN_CHECK_EN
    // Misaligned PC: straight to HOLD with a nop and the error flag.
    pc_val   = 64'h0000_0000_8000_0002;
    fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0;
    chk("mis_req", {63'd0, mem_req_valid}, 64'd0);
    chk("mis_valid", {63'd0, inst_valid}, 64'd1);
    chk("mis_err", {63'd0, inst_err}, 64'd1);
    chk("mis_inst", {32'd0, inst}, 64'h13);
    cyc();
    chk("mis_err_hold", {63'd0, inst_err}, 64'd1);
    chk("mis_req_hold", {63'd0, mem_req_valid}, 64'd0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("mis_err_clr", {63'd0, inst_err}, 64'd0);
    chk("mis_valid_clr", {63'd0, inst_valid}, 64'd0);
`else
    chk("no_feat_err", {63'd0, inst_err}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
